// File: rtl/branch_resolve.sv
// ============================================================================
// Module   : branch_resolve
// Purpose  : Resolves conditional branches against a forwarded {Z,V,N} flag
//            register, waiting (bounded) for in-flight flag-writing ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] flags_in,
  input  logic [2:0] flag_wr,
  input  logic       flag_pend,
  input  logic       br_valid,
  input  logic [2:0] br_cond,
  output logic       br_ready,
  output logic       res_valid,
  output logic       res_taken,
  output logic       res_err,
  output logic [2:0] flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] C_UNCOND  = 3'b111;
  // Last counter value before the increment that reaches TIMEOUT-1.
  localparam logic [7:0] C_CNT_END = 8'(TIMEOUT - 2);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] cond_q, cond_d;
  logic [2:0] flags_q;
  logic       taken_q, taken_d;
  logic       err_q, err_d;
  logic [2:0] eff_flags;

  function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      3'b000:  cond_eval = !z;
      3'b001:  cond_eval = z;
      3'b010:  cond_eval = !z && !n;
      3'b011:  cond_eval = n;
      3'b100:  cond_eval = z || !n;
      3'b101:  cond_eval = z || n;
      3'b110:  cond_eval = v;
      default: cond_eval = 1'b1;
    endcase
  endfunction

  assign eff_flags = (flags_q & ~flag_wr) | (flags_in & flag_wr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cond_d  = cond_q;
    taken_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          cond_d = br_cond;
          if (!flag_pend || br_cond == C_UNCOND) begin
            state_d = S_RESP;
            taken_d = cond_eval(br_cond, eff_flags);
          end else begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
          end
        end
      end
      S_WAIT: begin
        if (!flag_pend) begin
          state_d = S_RESP;
          taken_d = cond_eval(cond_q, eff_flags);
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == C_CNT_END) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      cond_q  <= 3'd0;
      flags_q <= 3'd0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cond_q  <= cond_d;
      flags_q <= eff_flags;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  assign br_ready  = (state_q == S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign res_taken = taken_q;
  assign res_err   = err_q;
  assign flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
// Module   : tb_branch_resolve
// Purpose  : Self-checking bench for branch_resolve (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] flags_in = '0;
  logic [2:0] flag_wr = '0;
  logic       flag_pend = 1'b0;
  logic       br_valid = 1'b0;
  logic [2:0] br_cond = '0;
  logic       br_ready, res_valid, res_taken, res_err;
  logic [2:0] flags;

  branch_resolve #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .flags_in(flags_in), .flag_wr(flag_wr),
    .flag_pend(flag_pend), .br_valid(br_valid), .br_cond(br_cond),
    .br_ready(br_ready), .res_valid(res_valid), .res_taken(res_taken),
    .res_err(res_err), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic taken;
    logic err;
    int   at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [2:0] cond;
    logic [2:0] f;
    logic       exp;
  } vec_t;
  vec_t vt[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference branch condition table, written from the condition names.
  function automatic logic ref_taken(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    {z, v, n} = f;
    case (c)
      3'd0: return z == 1'b0;
      3'd1: return z == 1'b1;
      3'd2: return (z == 1'b0) && (n == 1'b0);
      3'd3: return n == 1'b1;
      3'd4: return (z == 1'b1) || (n == 1'b0);
      3'd5: return (z == 1'b1) || (n == 1'b1);
      3'd6: return v == 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("res_taken", res_taken, mon_e.taken);
        chk("res_err", res_err, mon_e.err);
        chk("res_cycle", cyc, mon_e.at);
      end
    end else if (!rst) begin
      chk("res_valid_known", res_valid, 0);
      chk("idle_taken_err", {res_taken, res_err}, 0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    br_valid = 1'b0;
    flag_wr  = 3'b000;
    flags_in = 3'b000;
  endtask

  task automatic write_flags(input logic [2:0] f);
    quiet();
    flag_wr  = 3'b111;
    flags_in = f;
    next_cycle();
    quiet();
  endtask

  task automatic push(input logic t, input logic e, input int at);
    exp_t x;
    x.taken = t;
    x.err   = e;
    x.at    = at;
    sb.push_back(x);
  endtask

  int a;

  initial begin
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++) begin
        vt[c*8+f].cond = 3'(c);
        vt[c*8+f].f    = 3'(f);
        vt[c*8+f].exp  = ref_taken(3'(c), 3'(f));
      end

    next_cycle();
    next_cycle();
    rst = 1'b0;
    chk("reset_br_ready", br_ready, 1);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_flags", flags, 3'b000);

    // Write Z then branch EQ.
    write_flags(3'b100);
    br_valid = 1'b1; br_cond = 3'b001;
    push(1'b1, 1'b0, cyc + 1);
    next_cycle(); quiet();
    chk("eq_flags", flags, 3'b100);
    chk("eq_resp_not_ready", br_ready, 0);
    next_cycle();

    // Same-cycle forwarding of Z.
    write_flags(3'b000);
    br_valid = 1'b1; br_cond = 3'b001; flag_wr = 3'b100; flags_in = 3'b100;
    push(1'b1, 1'b0, cyc + 1);
    next_cycle(); quiet();
    chk("fwd_flags", flags, 3'b100);
    next_cycle();

    // Pending flags, LT; N arrives as pend drops after 3 cycles.
    write_flags(3'b000);
    br_valid = 1'b1; br_cond = 3'b011; flag_pend = 1'b1;
    a = cyc;
    next_cycle(); quiet();
    br_cond = 3'b001;
    for (int i = 1; i < 3; i++) begin
      chk("wait_not_ready", br_ready, 0);
      next_cycle();
    end
    chk("wait_not_ready", br_ready, 0);
    flag_pend = 1'b0; flag_wr = 3'b001; flags_in = 3'b001;
    push(1'b1, 1'b0, a + 4);
    next_cycle(); quiet();
    chk("wait_resp_not_ready", br_ready, 0);
    chk("wait_flags", flags, 3'b001);
    next_cycle();

    // Timeout with pend stuck high.
    write_flags(3'b000);
    br_valid = 1'b1; br_cond = 3'b000; flag_pend = 1'b1;
    a = cyc;
    push(1'b0, 1'b1, a + 16);
    next_cycle(); quiet();
    for (int i = 1; i < 16; i++) begin
      chk("timeout_not_ready", br_ready, 0);
      next_cycle();
    end
    next_cycle();
    flag_pend = 1'b0;
    chk("timeout_ready_after", br_ready, 1);

    // Unconditional with pend high skips WAIT.
    br_valid = 1'b1; br_cond = 3'b111; flag_pend = 1'b1;
    push(1'b1, 1'b0, cyc + 1);
    next_cycle(); quiet();
    chk("uncond_resp", br_ready, 0);
    next_cycle();
    chk("uncond_no_wait", br_ready, 1);
    flag_pend = 1'b0;

    // Full condition/flag sweep.
    for (int k = 0; k < 64; k++) begin
      write_flags(vt[k].f);
      chk("sweep_ready", br_ready, 1);
      chk("sweep_flags", flags, vt[k].f);
      br_valid = 1'b1; br_cond = vt[k].cond;
      push(vt[k].exp, 1'b0, cyc + 1);
      next_cycle(); quiet();
      next_cycle();
    end

    // Reset during WAIT aborts the request and clears flags.
    write_flags(3'b111);
    br_valid = 1'b1; br_cond = 3'b000; flag_pend = 1'b1;
    next_cycle(); quiet();
    next_cycle();
    next_cycle();
    chk("abort_in_wait", br_ready, 0);
    rst = 1'b1; flag_wr = 3'b111; flags_in = 3'b111;
    next_cycle();
    rst = 1'b0; quiet(); flag_pend = 1'b0;
    chk("abort_flags", flags, 3'b000);
    chk("abort_ready", br_ready, 1);
    for (int i = 0; i < 20; i++) next_cycle();

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
